keccak_theta_stream: RTL and testbench

Parametrised streaming successor to the column-parity datapath. It computes the Keccak theta step over a full 5x5xSLICES state that arrives one 25-bit slice per transfer. Unlike the previous two-input form, it derives the z-1 neighbour internally, handles the cyclic z wrap (slice 0 uses slice SLICES-1), supports valid/ready backpressure on both sides, and has a per-block bypass mode. It sits between the state memory and the rho/pi stage.

---
 rtl/keccak_theta_stream.sv | 169 ++++++++++++++++
 tb/tb_keccak_theta_stream.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_theta_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : keccak_theta_stream
// Description : Streaming Keccak theta step. A full 5x5xSLICES state arrives
//               one 25-bit slice (bit x+5y) per transfer, is buffered together
//               with its column parities, and is then emitted slice by slice
//               with theta applied (or passed through when the block was
//               started with bypass=1). Load and emit phases do not overlap.
// Ports       : clk, rst (async, active high)
//               in_valid/in_ready/in_data  - input slice stream
//               bypass                     - sampled with slice 0 of a block
//               out_valid/out_ready/out_data/out_last - output slice stream
//               busy                       - block in progress
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_theta_stream #(
   parameter  int SLICES = 64,
   localparam int CW     = $clog2(SLICES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [24:0] in_data,
   input  logic        bypass,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [24:0] out_data,
   output logic        out_last,
   output logic        busy
);

   localparam logic [0:0]    ST_LOAD  = 1'b0;
   localparam logic [0:0]    ST_EMIT  = 1'b1;
   localparam logic [CW-1:0] LAST_IDX = CW'(SLICES - 1);

   logic [0:0]    state_q,  state_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic          bypass_q, bypass_d;

   // State storage; contents are only meaningful once rewritten by a block.
   logic [24:0]   slice_mem_q [SLICES];
   logic [4:0]    par_mem_q   [SLICES];

   logic          in_fire;
   logic          out_fire;
   logic [4:0]    in_par;
   logic [CW-1:0] prev_idx;
   logic [24:0]   cur_slice;
   logic [4:0]    cur_par;
   logic [4:0]    prv_par;
   logic [4:0]    d_col;
   logic [24:0]   theta_slice;

   assign in_fire  = in_valid  & in_ready;
   assign out_fire = out_valid & out_ready;

   // Column parity of the incoming slice: C[x] = XOR over y of bit x+5y.
   always_comb begin
      in_par = '0;
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            in_par[x] = in_par[x] ^ in_data[x + 5*y];
         end
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         bypass_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         bypass_q  <= bypass_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         slice_mem_q[in_cnt_q] <= in_data;
         par_mem_q[in_cnt_q]   <= in_par;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      bypass_d  = bypass_q;
      case (state_q)
         ST_LOAD: begin
            if (in_fire) begin
               if (in_cnt_q == '0) begin
                  bypass_d = bypass;
               end
               if (in_cnt_q == LAST_IDX) begin
                  in_cnt_d = '0;
                  state_d  = ST_EMIT;
               end else begin
                  in_cnt_d = in_cnt_q + CW'(1);
               end
            end
         end
         ST_EMIT: begin
            if (out_fire) begin
               if (out_cnt_q == LAST_IDX) begin
                  out_cnt_d = '0;
                  state_d   = ST_LOAD;
               end else begin
                  out_cnt_d = out_cnt_q + CW'(1);
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // ------------------------------------------------------------------
   // Theta datapath on the slice being emitted
   // ------------------------------------------------------------------
   // Slice 0 takes its z-1 parity from the last slice of the same block.
   assign prev_idx = (out_cnt_q == '0) ? LAST_IDX : (out_cnt_q - CW'(1));

   always_comb begin
      cur_slice   = slice_mem_q[out_cnt_q];
      cur_par     = par_mem_q[out_cnt_q];
      prv_par     = par_mem_q[prev_idx];
      d_col       = '0;
      theta_slice = '0;
      for (int x = 0; x < 5; x++) begin
         d_col[x] = cur_par[(x + 4) % 5] ^ prv_par[(x + 1) % 5];
      end
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            theta_slice[x + 5*y] = cur_slice[x + 5*y] ^ d_col[x];
         end
      end
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = (state_q == ST_LOAD);
      out_valid = (state_q == ST_EMIT);
      out_last  = (state_q == ST_EMIT) && (out_cnt_q == LAST_IDX);
      busy      = (state_q == ST_EMIT) || (in_cnt_q != '0);
      // Gate with state so the buffer's undefined contents never leak out.
      if (state_q == ST_EMIT) begin
         out_data = bypass_q ? cur_slice : theta_slice;
      end else begin
         out_data = '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keccak_theta_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_keccak_theta_stream
// Description : Self-checking bench for keccak_theta_stream (SLICES=64 and a
//               second instance with SLICES=8). Table-driven single-bit
//               vectors, random blocks against a theta reference model,
//               random output stalls and a mid-emit reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_theta_stream;

   typedef logic [24:0] blk_t [64];
   typedef struct {
      logic [24:0] data;
      logic        last;
   } exp_t;
   typedef struct {
      int          pos;
      logic [24:0] val;
      logic        byp;
      int          p0;
      logic [24:0] e0;
      int          p1;
      logic [24:0] e1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, bypass, out_valid, out_ready, out_last, busy;
   logic [24:0] in_data, out_data;
   logic        in_valid8, in_ready8, bypass8, out_valid8, out_ready8, out_last8, busy8;
   logic [24:0] in_data8, out_data8;

   int   checks = 0;
   int   errors = 0;
   int   out_seen = 0;
   logic stall_mode = 1'b0;
   exp_t q[$];

   always #5 clk = ~clk;

   keccak_theta_stream #(.SLICES(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .bypass(bypass), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   keccak_theta_stream #(.SLICES(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data8), .bypass(bypass8), .out_valid(out_valid8),
      .out_ready(out_ready8), .out_data(out_data8), .out_last(out_last8), .busy(busy8)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference theta on an n-slice state: lanes A[x][y] bit z = slice z bit x+5y.
   function automatic void theta_model(input blk_t a, input int n, input logic byp, output blk_t r);
      logic [4:0] c [64];
      for (int z = 0; z < 64; z++) begin
         c[z] = '0;
         r[z] = '0;
      end
      for (int z = 0; z < n; z++)
         for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
               c[z][x] = c[z][x] ^ a[z][x + 5*y];
      for (int z = 0; z < n; z++) begin
         int zm;
         zm = (z + n - 1) % n;
         for (int x = 0; x < 5; x++) begin
            logic d;
            d = c[z][(x + 4) % 5] ^ c[zm][(x + 1) % 5];
            for (int y = 0; y < 5; y++)
               r[z][x + 5*y] = a[z][x + 5*y] ^ (byp ? 1'b0 : d);
         end
      end
   endfunction

   task automatic push_block(input blk_t e);
      exp_t ent;
      for (int z = 0; z < 64; z++) begin
         ent.data = e[z];
         ent.last = (z == 63);
         q.push_back(ent);
      end
   endtask

   task automatic load_block(input blk_t blk, input logic byp);
      int i;
      int guard;
      i = 0;
      guard = 0;
      while (i < 64 && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (i == 1) chk("busy_load", busy, 1'b1);
         in_valid = 1'b1;
         in_data  = blk[i];
         // bypass driven to the opposite value after slice 0 must be ignored
         bypass   = (i == 0) ? byp : ~byp;
         if (in_ready) i++;
      end
      if (i < 64) chk("load_timeout", i, 64);
      @(negedge clk);
      in_valid = 1'b0;
      bypass   = 1'b0;
      chk("latency_out_valid", out_valid, 1'b1);
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (q.size() != 0 && guard < 3000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
      @(negedge clk);
   endtask

   // Output monitor / scoreboard consumer for the 64-slice instance.
   initial begin
      logic        stalled;
      logic [24:0] sd;
      logic        sl;
      exp_t        e;
      stalled   = 1'b0;
      sd        = '0;
      sl        = 1'b0;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
            continue;
         end
         out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stalled && out_valid) begin
            chk("stall_data_stable", out_data, sd);
            chk("stall_last_stable", out_last, sl);
         end
         if (out_valid) chk("in_ready_in_emit", in_ready, 1'b0);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               chk("out_data", out_data, e.data);
               chk("out_last", out_last, e.last);
            end
            out_seen++;
         end
         stalled = out_valid && !out_ready;
         sd      = out_data;
         sl      = out_last;
      end
   end

   initial begin
      vec_t tbl [5];
      blk_t blk, exp_blk;
      blk_t blk8, r8;
      int   got, guard, base;
      logic st8;
      logic [24:0] sd8;
      logic sl8;

      tbl[0] = '{pos: 0,  val: 25'h0000000, byp: 1'b0, p0: -1, e0: 25'h0,       p1: -1, e1: 25'h0};
      tbl[1] = '{pos: 0,  val: 25'h0000001, byp: 1'b0, p0: 0,  e0: 25'h0210843, p1: 1,  e1: 25'h1084210};
      tbl[2] = '{pos: 63, val: 25'h0000001, byp: 1'b0, p0: 63, e0: 25'h0210843, p1: 0,  e1: 25'h1084210};
      tbl[3] = '{pos: 10, val: 25'h1000000, byp: 1'b0, p0: 10, e0: 25'h1108421, p1: 11, e1: 25'h0842108};
      tbl[4] = '{pos: 5,  val: 25'h0000001, byp: 1'b1, p0: 5,  e0: 25'h0000001, p1: -1, e1: 25'h0};

      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; bypass = 1'b0;
      in_valid8 = 1'b0; in_data8 = '0; bypass8 = 1'b0; out_ready8 = 1'b1;
      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_data", out_data, 25'h0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven single-bit patterns
      for (int t = 0; t < 5; t++) begin
         for (int z = 0; z < 64; z++) begin
            blk[z]     = '0;
            exp_blk[z] = '0;
         end
         blk[tbl[t].pos] = tbl[t].val;
         if (tbl[t].p0 >= 0) exp_blk[tbl[t].p0] = tbl[t].e0;
         if (tbl[t].p1 >= 0) exp_blk[tbl[t].p1] = tbl[t].e1;
         push_block(exp_blk);
         load_block(blk, tbl[t].byp);
         wait_drain();
      end
      chk("idle_busy", busy, 1'b0);

      // Random block in bypass, then random block with theta
      for (int z = 0; z < 64; z++) blk[z] = 25'($urandom());
      push_block(blk);
      load_block(blk, 1'b1);
      wait_drain();
      for (int z = 0; z < 64; z++) blk[z] = 25'($urandom());
      theta_model(blk, 64, 1'b0, exp_blk);
      push_block(exp_blk);
      load_block(blk, 1'b0);
      wait_drain();

      // Random output stalls
      stall_mode = 1'b1;
      for (int z = 0; z < 64; z++) blk[z] = 25'($urandom());
      theta_model(blk, 64, 1'b0, exp_blk);
      push_block(exp_blk);
      load_block(blk, 1'b0);
      wait_drain();
      stall_mode = 1'b0;

      // SLICES=8 instance with random stalls
      for (int z = 0; z < 64; z++) blk8[z] = (z < 8) ? 25'($urandom()) : 25'h0;
      theta_model(blk8, 8, 1'b0, r8);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("s8_in_ready", in_ready8, 1'b1);
         in_valid8 = 1'b1;
         in_data8  = blk8[i];
      end
      @(negedge clk);
      in_valid8 = 1'b0;
      got = 0; guard = 0; st8 = 1'b0; sd8 = '0; sl8 = 1'b0;
      while (got < 8 && guard < 500) begin
         guard++;
         out_ready8 = 1'($urandom_range(0, 1));
         if (st8 && out_valid8) begin
            chk("s8_stall_data", out_data8, sd8);
            chk("s8_stall_last", out_last8, sl8);
         end
         if (out_valid8) chk("s8_in_ready_emit", in_ready8, 1'b0);
         if (out_valid8 && out_ready8) begin
            chk("s8_out_data", out_data8, r8[got]);
            chk("s8_out_last", out_last8, (got == 7));
            got++;
         end
         st8 = out_valid8 && !out_ready8;
         sd8 = out_data8;
         sl8 = out_last8;
         @(negedge clk);
      end
      if (got < 8) chk("s8_timeout", got, 8);
      out_ready8 = 1'b1;
      chk("s8_back_to_load", in_ready8, 1'b1);

      // Reset in the middle of EMIT after 10 outputs
      for (int z = 0; z < 64; z++) blk[z] = 25'($urandom());
      theta_model(blk, 64, 1'b0, exp_blk);
      push_block(exp_blk);
      base = out_seen;
      load_block(blk, 1'b0);
      guard = 0;
      while (out_seen < base + 10 && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("pre_reset_count", out_seen - base, 10);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      q.delete();
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int z = 0; z < 64; z++) blk[z] = 25'($urandom());
      theta_model(blk, 64, 1'b0, exp_blk);
      push_block(exp_blk);
      load_block(blk, 1'b0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
